// File: rtl/seg7_scan_driver_if.sv
// seg7_if: display bus between the processor top level and the scan driver.
//
// Signalling: this is a strobe/level bus, not a valid/ready handshake.
// 'load' is a one-cycle capture strobe that is always accepted, with no
// backpressure. 'din' and 'dp_in' are sampled on any edge where 'load' is
// high. 'blank' is a level that is not captured. 'an', 'seg' and 'dp' are
// registered, active-low board outputs.
interface seg7_if;
    logic [15:0] din;
    logic        load;
    logic [3:0]  dp_in;
    logic        blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output din, load, dp_in, blank,
        input  an, seg, dp
    );

    modport slave (
        input  din, load, dp_in, blank,
        output an, seg, dp
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: four-digit time-multiplexed seven-segment driver.
//
// The driver captures a 16-bit display word and a 4-bit decimal-point mask
// on 'load'. It then scans one hex digit at a time, giving each digit
// REFRESH_DIV cycles. The first GUARD cycles of every slot keep all anodes
// off so that the previous digit's segments do not ghost onto the next
// digit. All board outputs are registered and active-low.
//
// Optional build macro:
//   SEG7_LZB_EN - leading-zero blanking. Digits 3..1 go dark when their
//                 nibble and every higher nibble are zero. Digit 0 is never
//                 blanked. Anode timing and dp are unaffected.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4
) (
    input  logic  clk,
    input  logic  rst,
    seg7_if.slave bus
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

    // Elaboration-time parameter sanity checks.
    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("seg7_scan_driver: REFRESH_DIV must be at least 2");
    end
    if (GUARD < 0 || GUARD >= REFRESH_DIV) begin : g_bad_guard
        $error("seg7_scan_driver: GUARD must satisfy 0 <= GUARD < REFRESH_DIV");
    end

    // Hex font, active-low, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] f;
        case (nib)
            4'h0: f = 7'b1000000;
            4'h1: f = 7'b1111001;
            4'h2: f = 7'b0100100;
            4'h3: f = 7'b0110000;
            4'h4: f = 7'b0011001;
            4'h5: f = 7'b0010010;
            4'h6: f = 7'b0000010;
            4'h7: f = 7'b1111000;
            4'h8: f = 7'b0000000;
            4'h9: f = 7'b0010000;
            4'hA: f = 7'b0001000;
            4'hB: f = 7'b0000011;
            4'hC: f = 7'b1000110;
            4'hD: f = 7'b0100001;
            4'hE: f = 7'b0000110;
            default: f = 7'b0001110;
        endcase
        return f;
    endfunction

    logic [15:0]   shadow;
    logic [3:0]    shadow_dp;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;

    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    logic [3:0]    cur_nib;
    logic [3:0]    lz_dark;
    logic          in_guard;
    logic [6:0]    digit_seg;

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

    // Shadow register: captures the display word and dp mask on load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= 16'h0000;
            shadow_dp <= 4'b0000;
        end else if (bus.load) begin
            shadow    <= bus.din;
            shadow_dp <= bus.dp_in;
        end
    end

    // Free-running scan: the slot counter wraps and advances the digit
    // index. Load and blank never touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Select the nibble of the digit currently being scanned.
    always_comb begin
        cur_nib = shadow[3:0];
        case (idx)
            2'd0: cur_nib = shadow[3:0];
            2'd1: cur_nib = shadow[7:4];
            2'd2: cur_nib = shadow[11:8];
            2'd3: cur_nib = shadow[15:12];
            default: cur_nib = shadow[3:0];
        endcase
    end

    // Per-digit leading-zero mask. It is all zero unless blanking is built in.
    always_comb begin
        lz_dark = 4'b0000;
`ifdef SEG7_LZB_EN
        lz_dark[3] = (shadow[15:12] == 4'h0);
        lz_dark[2] = (shadow[15:8]  == 8'h00);
        lz_dark[1] = (shadow[15:4]  == 12'h000);
        lz_dark[0] = 1'b0;
`endif
    end

    // Segment pattern for the current digit, after optional zero blanking.
    always_comb begin
        in_guard  = (cnt < GUARD_C);
        digit_seg = lz_dark[idx] ? 7'b1111111 : hex_font(cur_nib);
    end

    // Registered board outputs. They reflect the scan state and shadow as
    // they stood before this edge, so they lag the counter by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
            dp_q  <= 1'b1;
        end else if (bus.blank || in_guard) begin
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= ~(4'b0001 << idx);
            seg_q <= digit_seg;
            dp_q  <= ~shadow_dp[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of the scan driver with
// REFRESH_DIV=8 and GUARD=2. Outputs are sampled on the falling edge.
module tb_seg7_scan_driver;

    localparam int RD = 8;
    localparam int G  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   k = 0;                 // rising edges since last reset release

    logic [6:0] font [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [6:0] tab  [4];        // expected lit segments per digit
    logic       dtab [4];        // expected dp per digit (active-low)

    localparam logic [11:0] DARK = {4'b1111, 7'b1111111, 1'b1};

    seg7_if bus();

    seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s k=%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    // Builds the expected per-digit table from a shadow value.
    task automatic set_shadow(input logic [15:0] v, input logic [3:0] d);
        for (int i = 0; i < 4; i++) begin
            tab[i]  = font[v[4*i +: 4]];
            dtab[i] = ~d[i];
        end
`ifdef SEG7_LZB_EN
        for (int i = 1; i < 4; i++)
            if ((v >> (4*i)) == 16'h0000) tab[i] = 7'b1111111;
`endif
    endtask

    // One clock, then compare the outputs against the slot position.
    task automatic tick();
        logic b;
        int p, d;
        logic [11:0] e;
        @(posedge clk);
        b = bus.blank;
        k++;
        @(negedge clk);
        p = (k - 1) % RD;
        d = ((k - 1) / RD) % 4;
        if (b || p < G) e = DARK;
        else            e = {~(4'b0001 << d), tab[d], dtab[d]};
        check("scan", {bus.an, bus.seg, bus.dp}, e);
        check("one_anode", {11'd0, ($countones(~bus.an) <= 1)}, 12'd1);
    endtask

    // Capture strobe for one edge; the new value shows one edge later.
    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.din   = v;
        bus.dp_in = d;
        bus.load  = 1'b1;
        tick();
        set_shadow(v, d);
        bus.load  = 1'b0;
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic reset_mid();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("reset_async", {bus.an, bus.seg, bus.dp}, DARK);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        set_shadow(16'h0000, 4'b0000);
    endtask

    initial begin
        bus.din   = 16'h0000;
        bus.dp_in = 4'b0000;
        bus.load  = 1'b0;
        bus.blank = 1'b0;
        set_shadow(16'h0000, 4'b0000);

        // Reset state, then the first lit digit three edges after release.
        #12;
        check("reset_state", {bus.an, bus.seg, bus.dp}, DARK);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        tick();
        tick();
        tick();
        check("first_lit", {bus.an, bus.seg, bus.dp}, {4'b1110, 7'b1000000, 1'b1});

        // Load in the middle of lit digit 0.
        do_load(16'h0008, 4'b0000);
        check("load_same_edge", {5'd0, bus.seg}, {5'd0, 7'b1000000});
        tick();
        check("load_next_edge", {bus.an, bus.seg, bus.dp}, {4'b1110, 7'b0000000, 1'b1});
        while (k < 29) tick();

        // Scan order over a full frame.
        do_load(16'h1A2F, 4'b0100);
        repeat (34) tick();

        // Leading-zero pattern with dp on digit 0.
        do_load(16'h0030, 4'b0001);
        repeat (32) tick();

        // Blank for 20 cycles; the scan continues underneath.
        bus.blank = 1'b1;
        repeat (20) tick();
        bus.blank = 1'b0;
        repeat (12) tick();

        // Load on the edge where the digit switches.
        while ((k % RD) != 0) tick();
        do_load(16'hBEEF, 4'b1010);
        repeat (16) tick();

        // Reset in the middle of a lit slot restarts at digit 0.
        while (((k - 1) % RD) < G + 1) tick();
        reset_mid();
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
